plab4_net_router_input_queue_dual_domain: RTL and testbench

//  Input buffering stage for one router input port in the two-domain (d0/d1) network.

---
 rtl/plab4_net_router_input_queue_dual_domain.sv | 120 ++++++++++++
 tb/tb_plab4_net_router_input_queue_dual_domain.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_input_queue_dual_domain.sv
// ---------------------------------------------------------------------------
// plab4_net_router_input_queue_dual_domain
//
// Input buffering for one router input port in the two-domain (d0/d1)
// network. Each incoming flit is steered by in_domain into its own per-domain
// circular FIFO. The two FIFOs share no storage, so traffic stalled in one
// domain can never block or reorder traffic in the other.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   in_val / in_rdy / in_msg upstream flit handshake; in_rdy reflects the
//   in_domain                 FIFO chosen by in_domain (0 -> d0, 1 -> d1)
//   out_val_dX / out_rdy_dX  per-domain head handshake toward the arbiter
//   out_msg_dX / dest_dX     per-domain head flit and its dest field
//   num_free_dX              free entries per domain (credit return)
// ---------------------------------------------------------------------------
module plab4_net_router_input_queue_dual_domain #(
   parameter int p_msg_nbits   = 44,
   parameter int p_num_routers = 8,
   parameter int p_num_entries = 4,
   parameter int c_dest_nbits  = $clog2(p_num_routers),
   parameter int c_cnt_nbits   = $clog2(p_num_entries + 1)
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    in_val,
   output logic                    in_rdy,
   input  logic [p_msg_nbits-1:0]  in_msg,
   input  logic                    in_domain,

   output logic                    out_val_d0,
   input  logic                    out_rdy_d0,
   output logic [p_msg_nbits-1:0]  out_msg_d0,
   output logic [c_dest_nbits-1:0] dest_d0,

   output logic                    out_val_d1,
   input  logic                    out_rdy_d1,
   output logic [p_msg_nbits-1:0]  out_msg_d1,
   output logic [c_dest_nbits-1:0] dest_d1,

   output logic [c_cnt_nbits-1:0]  num_free_d0,
   output logic [c_cnt_nbits-1:0]  num_free_d1
);

   localparam int c_ptr_nbits = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

   logic [p_msg_nbits-1:0] mem     [2][p_num_entries];
   logic [c_ptr_nbits-1:0] enq_ptr [2];
   logic [c_ptr_nbits-1:0] deq_ptr [2];
   logic [c_cnt_nbits-1:0] count   [2];

   logic [1:0] full;
   logic [1:0] not_empty;
   logic [1:0] enq;
   logic [1:0] deq;

   // Pointers wrap explicitly so depth need not be a power of two.
   function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
      return (p == c_ptr_nbits'(p_num_entries - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full      = '0;
      not_empty = '0;
      for (int d = 0; d < 2; d++) begin
         full[d]      = (count[d] == c_cnt_nbits'(p_num_entries));
         not_empty[d] = (count[d] != '0);
      end
   end

   // Full FIFOs refuse enqueue even if their head leaves in the same cycle.
   assign in_rdy = in_domain ? !full[1] : !full[0];

   always_comb begin
      enq    = '0;
      enq[0] = in_val && in_rdy && !in_domain;
      enq[1] = in_val && in_rdy &&  in_domain;
      deq    = '0;
      deq[0] = not_empty[0] && out_rdy_d0;
      deq[1] = not_empty[1] && out_rdy_d1;
   end

   // Storage is cleared on reset so heads never show X after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            enq_ptr[d] <= '0;
            deq_ptr[d] <= '0;
            count[d]   <= '0;
            for (int e = 0; e < p_num_entries; e++)
               mem[d][e] <= '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (enq[d]) begin
               mem[d][enq_ptr[d]] <= in_msg;
               enq_ptr[d]         <= ptr_inc(enq_ptr[d]);
            end
            if (deq[d])
               deq_ptr[d] <= ptr_inc(deq_ptr[d]);
            if (enq[d] && !deq[d])
               count[d] <= count[d] + 1'b1;
            else if (deq[d] && !enq[d])
               count[d] <= count[d] - 1'b1;
         end
      end
   end

   assign out_val_d0  = not_empty[0];
   assign out_msg_d0  = mem[0][deq_ptr[0]];
   assign dest_d0     = out_msg_d0[p_msg_nbits-1 -: c_dest_nbits];
   assign num_free_d0 = c_cnt_nbits'(p_num_entries) - count[0];

   assign out_val_d1  = not_empty[1];
   assign out_msg_d1  = mem[1][deq_ptr[1]];
   assign dest_d1     = out_msg_d1[p_msg_nbits-1 -: c_dest_nbits];
   assign num_free_d1 = c_cnt_nbits'(p_num_entries) - count[1];

endmodule

// File: tb/tb_plab4_net_router_input_queue_dual_domain.sv
module tb_plab4_net_router_input_queue_dual_domain;

   localparam int MW = 44;
   localparam int DW = 3;
   localparam int CW = 3;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_val;
   logic          in_rdy;
   logic [MW-1:0] in_msg;
   logic          in_domain;
   logic          out_val_d0, out_rdy_d0, out_val_d1, out_rdy_d1;
   logic [MW-1:0] out_msg_d0, out_msg_d1;
   logic [DW-1:0] dest_d0, dest_d1;
   logic [CW-1:0] num_free_d0, num_free_d1;

   int vecs = 0;
   int errs = 0;

   logic [MW-1:0] q0[$];
   logic [MW-1:0] q1[$];

   always #5 clk = ~clk;

   plab4_net_router_input_queue_dual_domain #(
      .p_msg_nbits(MW), .p_num_routers(8), .p_num_entries(N)
   ) dut (
      .clk(clk), .reset(reset),
      .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_domain(in_domain),
      .out_val_d0(out_val_d0), .out_rdy_d0(out_rdy_d0), .out_msg_d0(out_msg_d0), .dest_d0(dest_d0),
      .out_val_d1(out_val_d1), .out_rdy_d1(out_rdy_d1), .out_msg_d1(out_msg_d1), .dest_d1(dest_d1),
      .num_free_d0(num_free_d0), .num_free_d1(num_free_d1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MW-1:0] mk_msg(input int dest);
      logic [MW-1:0] m;
      m = MW'({$urandom(), $urandom()});
      m[MW-1 -: DW] = DW'(dest);
      return m;
   endfunction

   // Compare every head output against the reference queues.
   task automatic check_outputs();
      chk("out_val_d0", 64'(out_val_d0), 64'(q0.size() != 0));
      chk("out_val_d1", 64'(out_val_d1), 64'(q1.size() != 0));
      chk("num_free_d0", 64'(num_free_d0), 64'(N - q0.size()));
      chk("num_free_d1", 64'(num_free_d1), 64'(N - q1.size()));
      chk("msg_d0_known", 64'($isunknown(out_msg_d0)), 64'(0));
      chk("msg_d1_known", 64'($isunknown(out_msg_d1)), 64'(0));
      if (q0.size() != 0) begin
         chk("out_msg_d0", 64'(out_msg_d0), 64'(q0[0]));
         chk("dest_d0", 64'(dest_d0), 64'(q0[0] >> (MW - DW)));
      end
      if (q1.size() != 0) begin
         chk("out_msg_d1", 64'(out_msg_d1), 64'(q1[0]));
         chk("dest_d1", 64'(dest_d1), 64'(q1[0] >> (MW - DW)));
      end
   endtask

   // One clock: drive inputs, check in_rdy, advance the model, check heads.
   task automatic cycle(input bit rst, input bit v, input bit dom,
                        input logic [MW-1:0] m, input bit r0, input bit r1);
      bit exp_rdy, do_enq;
      reset      = rst;
      in_val     = v;
      in_domain  = dom;
      in_msg     = m;
      out_rdy_d0 = r0;
      out_rdy_d1 = r1;
      #1;
      exp_rdy = dom ? (q1.size() < N) : (q0.size() < N);
      chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         do_enq = v && exp_rdy;
         if (r0 && q0.size() != 0) void'(q0.pop_front());
         if (r1 && q1.size() != 0) void'(q1.pop_front());
         if (do_enq) begin
            if (dom) q1.push_back(m);
            else     q0.push_back(m);
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      reset = 1'b1; in_val = 1'b0; in_domain = 1'b0; in_msg = '0;
      out_rdy_d0 = 1'b0; out_rdy_d1 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;

      // Reset / idle, in_rdy for both domain selections
      cycle(0, 0, 0, '0, 0, 0);
      cycle(0, 0, 1, '0, 1, 1);
      chk("idle_free_d0", 64'(num_free_d0), 64'(4));
      chk("idle_free_d1", 64'(num_free_d1), 64'(4));

      // Single enqueue with dest=3 into d0
      cycle(0, 1, 0, mk_msg(3), 0, 0);
      chk("t2_val_d0", 64'(out_val_d0), 64'(1));
      chk("t2_dest_d0", 64'(dest_d0), 64'(3));
      chk("t2_val_d1", 64'(out_val_d1), 64'(0));
      chk("t2_free_d0", 64'(num_free_d0), 64'(3));

      // Fill d0, then attempt a 5th while its head dequeues; d1 still accepts
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, mk_msg(i), 0, 0);
      cycle(0, 1, 0, mk_msg(7), 1, 0);
      chk("t3_free_d0", 64'(num_free_d0), 64'(1));
      cycle(0, 1, 1, mk_msg(5), 0, 0);
      chk("t3_d1_accept", 64'(out_val_d1), 64'(1));
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0, 1, 1);

      // Streaming with continuous dequeue, pointers wrap repeatedly
      for (int i = 0; i < 12; i++) cycle(0, 1, 0, mk_msg(i % 8), 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, 0);

      // Interleaved domains, d0 held while d1 drains
      cycle(0, 1, 0, mk_msg(1), 0, 0);
      cycle(0, 1, 1, mk_msg(2), 0, 0);
      cycle(0, 1, 0, mk_msg(3), 0, 0);
      cycle(0, 1, 1, mk_msg(4), 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 0, 1);
      chk("t5_d0_held", 64'(num_free_d0), 64'(2));
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, 0);

      // Fill both, then reset for one cycle
      for (int i = 0; i < 2 * N; i++) cycle(0, 1, i[0], mk_msg(i), 0, 0);
      cycle(1, 0, 0, '0, 0, 0);
      chk("t6_val_d0", 64'(out_val_d0), 64'(0));
      chk("t6_val_d1", 64'(out_val_d1), 64'(0));
      cycle(0, 0, 1, '0, 0, 0);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) == 0,
               $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)),
               mk_msg($urandom_range(0, 7)),
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 1) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
